// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART frame transmitter: 55 AA <payload bytes> <checksum>, 8N1, LSB first.
// Ports: sys_clk, sys_rst_n (sync, active-low), send_start, tx_payload -> uart_txd, tx_busy, tx_done.
module uart_mult_byte_tx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int UART_BPS  = 115200,
   parameter int NUM_BYTES = 12
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   input  logic                   send_start,
   input  logic [8*NUM_BYTES-1:0] tx_payload,
   output logic                   uart_txd,
   output logic                   tx_busy,
   output logic                   tx_done
);

   localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
   localparam int CNT_W     = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam int LAST_BYTE = NUM_BYTES + 2;
   localparam int BYTE_W    = $clog2(NUM_BYTES + 3);

   typedef enum logic [1:0] {
      IDLE,
      START_BIT,
      DATA_BITS,
      STOP_BIT
   } state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_baud_cnt;
   logic [2:0]             r_bit_idx;
   logic [BYTE_W-1:0]      r_byte_idx;
   logic [8*NUM_BYTES-1:0] r_payload;

   logic       w_baud_end;
   logic [7:0] w_checksum;
   logic [7:0] w_byte;

   assign w_baud_end = (r_baud_cnt == CNT_W'(BPS_CNT - 1));

   // Derived from the latched payload, so it is stable for the whole frame.
   always_comb begin
      w_checksum = 8'h00;
      for (int k = 0; k < NUM_BYTES; k++) begin
         w_checksum = w_checksum + r_payload[8*k +: 8];
      end
   end

   // Byte currently on the line; the last index falls through to the checksum.
   always_comb begin
      w_byte = w_checksum;
      if (r_byte_idx == BYTE_W'(0)) begin
         w_byte = 8'h55;
      end else if (r_byte_idx == BYTE_W'(1)) begin
         w_byte = 8'hAA;
      end else begin
         for (int k = 0; k < NUM_BYTES; k++) begin
            if (r_byte_idx == BYTE_W'(k + 2)) begin
               w_byte = r_payload[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         uart_txd   <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_baud_cnt <= '0;
               r_bit_idx  <= '0;
               r_byte_idx <= '0;
               uart_txd   <= 1'b1;
               if (send_start) begin
                  r_payload <= tx_payload;
                  uart_txd  <= 1'b0;
                  tx_busy   <= 1'b1;
                  r_state   <= START_BIT;
               end
            end
            START_BIT: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  r_bit_idx  <= '0;
                  uart_txd   <= w_byte[0];
                  r_state    <= DATA_BITS;
               end else begin
                  r_baud_cnt <= r_baud_cnt + CNT_W'(1);
               end
            end
            DATA_BITS: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
                     uart_txd <= 1'b1;
                     r_state  <= STOP_BIT;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     uart_txd  <= w_byte[r_bit_idx + 3'd1];
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + CNT_W'(1);
               end
            end
            STOP_BIT: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  if (r_byte_idx == BYTE_W'(LAST_BYTE)) begin
                     r_byte_idx <= '0;
                     tx_busy    <= 1'b0;
                     tx_done    <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     // Next start bit follows the stop bit with no idle gap.
                     r_byte_idx <= r_byte_idx + BYTE_W'(1);
                     uart_txd   <= 1'b0;
                     r_state    <= START_BIT;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Directed bench for uart_mult_byte_tx: table of payloads plus reset,
// ignore-while-busy, back-to-back and mid-frame abort sequences.
module tb_uart_mult_byte_tx;

   localparam int NB    = 12;
   // 50 MHz / 4.8 MBd = 10.41..., truncated to 10 clocks per bit.
   localparam int BPS   = 10;
   localparam int SLOTS = (NB + 3) * 10;
   localparam int TOTAL = SLOTS * BPS;

   typedef struct {
      logic [8*NB-1:0] payload;
      logic [7:0]      cs;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            send_start = 1'b0;
   logic [8*NB-1:0] payload = '0;
   logic            txd;
   logic            busy;
   logic            done;

   int unsigned cyc = 0;
   int unsigned e0 = 0;
   int unsigned done_cnt = 0;
   int unsigned d0;
   int          n_vec = 0;
   int          n_err = 0;
   vec_t        vecs[4];

   uart_mult_byte_tx #(
      .CLK_FREQ (50_000_000),
      .UART_BPS (4_800_000),
      .NUM_BYTES(NB)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .send_start(send_start),
      .tx_payload(payload),
      .uart_txd  (txd),
      .tx_busy   (busy),
      .tx_done   (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic wait_to(input int unsigned tgt);
      while (cyc - e0 < tgt) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic launch(input logic [8*NB-1:0] pl, input bit hold);
      @(negedge clk);
      payload    = pl;
      send_start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      if (!hold) send_start = 1'b0;
   endtask

   function automatic logic [7:0] exp_byte(input logic [8*NB-1:0] pl,
                                           input logic [7:0] cs, input int b);
      if (b == 0) return 8'h55;
      if (b == 1) return 8'hAA;
      if (b == NB + 2) return cs;
      return pl[8*(b-2) +: 8];
   endfunction

   // Samples every bit at its first, middle and last clock.
   task automatic check_frame(input string tag, input logic [8*NB-1:0] pl,
                              input logic [7:0] cs);
      logic [9:0] lo, mid, hi, req;
      logic       bad_ctl;
      int         p;
      bad_ctl = 1'b0;
      lo = '0;
      mid = '0;
      hi = '0;
      for (int s = 0; s < SLOTS; s++) begin
         p = s % 10;
         wait_to(s * BPS);
         lo[p] = txd;
         if (!busy || done) bad_ctl = 1'b1;
         wait_to(s * BPS + BPS / 2);
         mid[p] = txd;
         if (!busy || done) bad_ctl = 1'b1;
         wait_to(s * BPS + BPS - 1);
         hi[p] = txd;
         if (!busy || done) bad_ctl = 1'b1;
         if (p == 9) begin
            req = {1'b1, exp_byte(pl, cs, s / 10), 1'b0};
            n_vec++;
            if (lo !== req || mid !== req || hi !== req) begin
               n_err++;
               $display("FAIL %s byte %0d: got lo=%03h mid=%03h hi=%03h expected %03h",
                        tag, s / 10, lo, mid, hi, req);
            end
         end
      end
      check({tag, " busy/done in frame"}, 32'(bad_ctl), 32'd0);
      wait_to(TOTAL);
      check({tag, " txd/busy/done at end"}, {29'd0, txd, busy, done}, 32'b101);
   endtask

   initial begin
      for (int k = 0; k < NB; k++) begin
         vecs[0].payload[8*k +: 8] = 8'h00;
         vecs[1].payload[8*k +: 8] = 8'(k + 1);
         vecs[2].payload[8*k +: 8] = 8'hFF;
         vecs[3].payload[8*k +: 8] = 8'(8'h10 + k);
      end
      vecs[0].cs = 8'h00;
      vecs[1].cs = 8'h4E;
      vecs[2].cs = 8'hF4;
      vecs[3].cs = 8'h02;

      // Reset held with send_start asserted.
      rst_n      = 1'b0;
      send_start = 1'b1;
      payload    = vecs[1].payload;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("reset hold", {29'd0, txd, busy, done}, 32'b100);
      end
      send_start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("idle after reset", {29'd0, txd, busy, done}, 32'b100);
      end

      for (int i = 0; i < 4; i++) begin
         d0 = done_cnt;
         launch(vecs[i].payload, 1'b0);
         check_frame($sformatf("vec%0d", i), vecs[i].payload, vecs[i].cs);
         @(posedge clk);
         #1;
         check("idle after frame", {29'd0, txd, busy, done}, 32'b100);
         check("done count", done_cnt, d0 + 1);
      end

      // Extra request and payload change mid-frame are ignored.
      d0 = done_cnt;
      launch(vecs[1].payload, 1'b0);
      fork
         check_frame("ignore", vecs[1].payload, vecs[1].cs);
         begin
            wait_to(100);
            send_start = 1'b1;
            payload    = vecs[2].payload;
            @(posedge clk);
            #1;
            send_start = 1'b0;
         end
      join
      @(posedge clk);
      #1;
      check("ignore idle", {29'd0, txd, busy, done}, 32'b100);
      repeat (20) @(posedge clk);
      #1;
      check("ignore done count", done_cnt, d0 + 1);

      // send_start held high: back-to-back frames, one idle cycle apart.
      d0 = done_cnt;
      launch(vecs[3].payload, 1'b1);
      fork
         check_frame("b2b first", vecs[3].payload, vecs[3].cs);
         begin
            wait_to(50);
            payload = vecs[0].payload;
         end
      join
      @(posedge clk);
      #1;
      e0 = cyc;
      check_frame("b2b second", vecs[0].payload, vecs[0].cs);
      send_start = 1'b0;
      @(posedge clk);
      #1;
      check("b2b idle", {29'd0, txd, busy, done}, 32'b100);
      check("b2b done count", done_cnt, d0 + 2);

      // One-cycle reset during payload byte 5 aborts the frame.
      d0 = done_cnt;
      launch(vecs[2].payload, 1'b0);
      wait_to(70 * BPS + 3 * BPS);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort", {29'd0, txd, busy, done}, 32'b100);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("abort idle", {29'd0, txd, busy, done}, 32'b100);
      check("abort no done", done_cnt, d0);
      launch(vecs[1].payload, 1'b0);
      check_frame("after abort", vecs[1].payload, vecs[1].cs);
      @(posedge clk);
      #1;
      check("after abort idle", {29'd0, txd, busy, done}, 32'b100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
